// File: rtl/i2c_master_burst.sv
// rtl/i2c_master_burst.sv - burst I2C master: one address phase followed by up to MAX_BYTES data bytes
//
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   start, addr, rw, len  transaction request (accepted while ready=1, len=0 is an address-only probe)
//   wdata/wvalid/wready   write-byte stream, byte moves when wvalid & wready
//   rdata/rvalid          received byte with one-cycle valid pulse
//   scl_oe, sda_oe        open-drain drivers, 1 pulls the line low
//   scl_i, sda_i          sampled bus line levels
//   ready, ack_err, done  idle flag, sticky NACK flag, one-cycle completion pulse
// Build option: I2C_CLK_STRETCH_EN lets a slave stretch SCL by holding it low while released.
module i2c_master_burst #(
    parameter int DIV       = 4,
    parameter int MAX_BYTES = 4,
    parameter int LEN_W     = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [6:0]       addr,
    input  logic             rw,
    input  logic [LEN_W-1:0] len,
    input  logic [7:0]       wdata,
    input  logic             wvalid,
    output logic             wready,
    output logic [7:0]       rdata,
    output logic             rvalid,
    output logic             scl_oe,
    output logic             sda_oe,
    input  logic             scl_i,
    input  logic             sda_i,
    output logic             ready,
    output logic             ack_err,
    output logic             done
);

    typedef enum logic [3:0] {IDLE, START, ADDR, AACK, WBYTE, WACK, RBYTE, RACK, STOP} state_t;

    localparam logic [7:0]       PRE_MAX = 8'(DIV - 1);
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BYTES);
    localparam logic [LEN_W-1:0] ONE     = LEN_W'(1);

    state_t           state, state_nx;
    logic [7:0]       pre;
    logic [1:0]       qtr;
    logic [2:0]       bit_cnt;
    logic [7:0]       shreg;
    logic             rw_q;
    logic [LEN_W-1:0] cnt;
    logic             ack_bit;

    logic bit_state, w_slot, s_stall, adv, tick, bit_end, sample;

    assign bit_state = state inside {ADDR, AACK, WBYTE, WACK, RBYTE, RACK};

    // First cycle of a write byte: the byte is fetched here, and the bit
    // timer waits (SCL low) until the stream supplies it.
    assign w_slot = (state == WBYTE) && (bit_cnt == 3'd0) && (qtr == 2'd0) && (pre == 8'd0);

`ifdef I2C_CLK_STRETCH_EN
    // SCL is released in quarters 1 and 2; a low line there means the slave stretches.
    assign s_stall = bit_state && ((qtr == 2'd1) || (qtr == 2'd2)) && !scl_i;
`else
    logic unused_scl;
    assign unused_scl = scl_i;
    assign s_stall    = 1'b0;
`endif

    assign adv     = (state != IDLE) && !(w_slot && !wvalid) && !s_stall;
    assign tick    = adv && (pre == PRE_MAX);
    assign bit_end = tick && (qtr == 2'd3);
    assign sample  = tick && (qtr == 2'd2);

    always_comb begin
        state_nx = state;
        scl_oe   = 1'b0;
        sda_oe   = 1'b0;
        wready   = 1'b0;
        ready    = 1'b0;
        if (bit_state) begin
            scl_oe = (qtr == 2'd0) || (qtr == 2'd3);
        end
        case (state)
            IDLE: begin
                // done cycle still counts as busy
                ready = !done;
                if (start && !done && (len <= MAX_LEN)) state_nx = START;
            end
            START: begin
                sda_oe = 1'b1;
                scl_oe = qtr[1];
                if (bit_end) state_nx = ADDR;
            end
            ADDR: begin
                sda_oe = !shreg[7];
                if (bit_end && bit_cnt == 3'd7) state_nx = AACK;
            end
            AACK: begin
                if (bit_end) begin
                    if (ack_bit || cnt == '0) state_nx = STOP;
                    else if (rw_q)            state_nx = RBYTE;
                    else                      state_nx = WBYTE;
                end
            end
            WBYTE: begin
                wready = w_slot;
                sda_oe = !shreg[7];
                if (bit_end && bit_cnt == 3'd7) state_nx = WACK;
            end
            WACK: begin
                if (bit_end) state_nx = (ack_bit || cnt == ONE) ? STOP : WBYTE;
            end
            RBYTE: begin
                if (bit_end && bit_cnt == 3'd7) state_nx = RACK;
            end
            RACK: begin
                // ACK while more bytes are wanted, NACK on the last one
                sda_oe = (cnt != ONE);
                if (bit_end) state_nx = (cnt == ONE) ? STOP : RBYTE;
            end
            STOP: begin
                scl_oe = (qtr == 2'd0);
                sda_oe = (qtr != 2'd3);
                if (bit_end) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            pre     <= 8'd0;
            qtr     <= 2'd0;
            bit_cnt <= 3'd0;
            shreg   <= 8'd0;
            rw_q    <= 1'b0;
            cnt     <= '0;
            ack_bit <= 1'b0;
            rdata   <= 8'd0;
            rvalid  <= 1'b0;
            done    <= 1'b0;
            ack_err <= 1'b0;
        end else begin
            state  <= state_nx;
            rvalid <= 1'b0;
            done   <= 1'b0;
            if (adv) begin
                if (pre == PRE_MAX) begin
                    pre <= 8'd0;
                    qtr <= qtr + 2'd1;
                end else begin
                    pre <= pre + 8'd1;
                end
            end
            case (state)
                IDLE: begin
                    if (state_nx == START) begin
                        shreg   <= {addr, rw};
                        rw_q    <= rw;
                        cnt     <= len;
                        ack_err <= 1'b0;
                        pre     <= 8'd0;
                        qtr     <= 2'd0;
                        bit_cnt <= 3'd0;
                    end
                end
                ADDR: begin
                    if (bit_end) begin
                        shreg   <= {shreg[6:0], 1'b0};
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                end
                WBYTE: begin
                    if (w_slot && wvalid) shreg <= wdata;
                    if (bit_end) begin
                        shreg   <= {shreg[6:0], 1'b0};
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                end
                RBYTE: begin
                    if (sample) begin
                        shreg <= {shreg[6:0], sda_i};
                        if (bit_cnt == 3'd7) begin
                            rdata  <= {shreg[6:0], sda_i};
                            rvalid <= 1'b1;
                        end
                    end
                    if (bit_end) bit_cnt <= bit_cnt + 3'd1;
                end
                AACK, WACK: begin
                    if (sample) ack_bit <= sda_i;
                    if (bit_end) begin
                        if (ack_bit)              ack_err <= 1'b1;
                        else if (state == WACK)   cnt     <= cnt - ONE;
                    end
                end
                RACK: begin
                    if (bit_end) cnt <= cnt - ONE;
                end
                STOP: begin
                    if (bit_end) done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_master_burst.sv
// tb/tb_i2c_master_burst.sv - scoreboard bench for i2c_master_burst with scripted I2C slave
module tb_i2c_master_burst;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [6:0] addr = 7'd0;
    logic       rw = 1'b0;
    logic [2:0] len = 3'd0;
    logic [7:0] wdata = 8'd0;
    logic       wvalid = 1'b0;
    logic       wready, rvalid, scl_oe, sda_oe, ready, ack_err, done;
    logic [7:0] rdata;
    logic       scl_i, sda_i;
    logic       slave_drive = 1'b0;
    logic       scl_hold = 1'b0;

    assign scl_i = !scl_oe && !scl_hold;
    assign sda_i = !(sda_oe || slave_drive);

    i2c_master_burst #(.DIV(4), .MAX_BYTES(4), .LEN_W(3)) dut (
        .clk(clk), .reset(reset), .start(start), .addr(addr), .rw(rw), .len(len),
        .wdata(wdata), .wvalid(wvalid), .wready(wready),
        .rdata(rdata), .rvalid(rvalid),
        .scl_oe(scl_oe), .sda_oe(sda_oe), .scl_i(scl_i), .sda_i(sda_i),
        .ready(ready), .ack_err(ack_err), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] bits;
        int          n;
    } frame_t;

    frame_t     exp_frames[$];
    logic [7:0] exp_rdata[$];
    logic       exp_done[$];
    logic [7:0] wq[$];

    int          checks = 0;
    int          errors = 0;
    logic [63:0] ef, es, script;
    int          en;
    logic [63:0] cur;
    int          nbits;
    logic        p_scl = 1'b1, p_sda = 1'b1, p_wready = 1'b0, in_txn = 1'b0;
    int          wr_rises = 0;
    frame_t      fpop;
    logic [63:0] mask;
    logic        stall_ok;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fbegin();
        ef = '0; es = '0; en = 0;
    endtask

    // a = expected bus ACK bit; sdat = slave drives the data bits; sack = slave drives the ACK bit
    task automatic fbyte(input logic [7:0] b, input logic a, input logic sdat, input logic sack);
        for (int i = 0; i < 8; i++) begin
            ef[en] = b[7-i];
            es[en] = sdat & ~b[7-i];
            en++;
        end
        ef[en] = a;
        es[en] = sack & ~a;
        en++;
    endtask

    task automatic fpush();
        exp_frames.push_back('{bits: ef, n: en});
        script = es;
    endtask

    task automatic run_txn(input logic [6:0] a, input logic r, input logic [2:0] l);
        @(negedge clk);
        addr = a; rw = r; len = l; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("ready_after_start", 64'(ready), 64'd0);
    endtask

    task automatic wait_done(input int exp_cyc);
        int n;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!done && n < 5000);
        chk("done_seen", 64'(done), 64'd1);
        if (exp_cyc >= 0) chk("txn_cycles", 64'(n), 64'(exp_cyc));
        chk("ready_in_done_cycle", 64'(ready), 64'd0);
        @(posedge clk); #1;
        chk("ready_after_done", 64'(ready), 64'd1);
    endtask

    initial begin
        fork
            begin : stim
                repeat (3) @(posedge clk);
                #1;
                chk("reset_state", {ready, scl_oe, sda_oe, wready, rvalid, done, ack_err, rdata},
                    {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00});
                @(negedge clk); reset = 1'b0;

                // write 0x55, one byte 0xAA, all ACKed
                fbegin(); fbyte(8'hAA, 1'b0, 1'b0, 1'b1); fbyte(8'hAA, 1'b0, 1'b0, 1'b1); fpush();
                exp_done.push_back(1'b0);
                wq.push_back(8'hAA);
                run_txn(7'h55, 1'b0, 3'd1);
                wait_done(320);

                // address-only probe, slave NACKs
                fbegin(); fbyte(8'h40, 1'b1, 1'b0, 1'b1); fpush();
                exp_done.push_back(1'b1);
                run_txn(7'h20, 1'b0, 3'd0);
                wait_done(176);
                chk("ack_err_sticky", 64'(ack_err), 64'd1);

                // read two bytes 0x01, 0xD3: master ACKs first, NACKs last
                fbegin(); fbyte(8'hAB, 1'b0, 1'b0, 1'b1); fbyte(8'h01, 1'b0, 1'b1, 1'b0);
                fbyte(8'hD3, 1'b1, 1'b1, 1'b0); fpush();
                exp_rdata.push_back(8'h01); exp_rdata.push_back(8'hD3);
                exp_done.push_back(1'b0);
                run_txn(7'h55, 1'b1, 3'd2);
                wait_done(464);

                // write three bytes, second data byte NACKed
                fbegin(); fbyte(8'h78, 1'b0, 1'b0, 1'b1); fbyte(8'h11, 1'b0, 1'b0, 1'b1);
                fbyte(8'h22, 1'b1, 1'b0, 1'b1); fpush();
                exp_done.push_back(1'b1);
                wr_rises = 0;
                wq.push_back(8'h11); wq.push_back(8'h22); wq.push_back(8'h33);
                run_txn(7'h3C, 1'b0, 3'd3);
                wait_done(464);
                chk("wready_count", 64'(wr_rises), 64'd2);
                chk("bytes_left", 64'(wq.size()), 64'd1);
                wq.delete();
                @(negedge clk); @(negedge clk);

                // write two bytes with a 50-cycle stall before the second
                fbegin(); fbyte(8'hAA, 1'b0, 1'b0, 1'b1); fbyte(8'hC5, 1'b0, 1'b0, 1'b1);
                fbyte(8'h3A, 1'b0, 1'b0, 1'b1); fpush();
                exp_done.push_back(1'b0);
                wq.push_back(8'hC5);
                run_txn(7'h55, 1'b0, 3'd2);
                begin
                    int w;
                    w = 0;
                    do begin
                        @(negedge clk);
                        w++;
                    end while (!(wready && wq.size() == 0) && w < 2000);
                end
                chk("stall_reached", 64'(wready), 64'd1);
                stall_ok = 1'b1;
                for (int i = 0; i < 50; i++) begin
                    @(negedge clk);
                    if (!(scl_oe && wready)) stall_ok = 1'b0;
                end
                chk("scl_low_during_stall", 64'(stall_ok), 64'd1);
                wq.push_back(8'h3A);
                wait_done(-1);

                // reset in the middle of a read byte, then an oversize request
                fbegin(); fbyte(8'hAB, 1'b0, 1'b0, 1'b1); fbyte(8'h5A, 1'b0, 1'b1, 1'b0);
                fbyte(8'h5A, 1'b1, 1'b1, 1'b0);
                script = es;
                run_txn(7'h55, 1'b1, 3'd2);
                repeat (199) @(posedge clk);
                @(negedge clk); reset = 1'b1;
                @(posedge clk); #1;
                chk("mid_reset_state", {ready, scl_oe, sda_oe, wready, rvalid, done, ack_err, rdata},
                    {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00});
                repeat (2) @(negedge clk);
                reset = 1'b0;
                @(negedge clk);
                addr = 7'h55; rw = 1'b0; len = 3'd5; start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
                stall_ok = 1'b1;
                for (int i = 0; i < 20; i++) begin
                    @(negedge clk);
                    if (!ready || scl_oe || sda_oe) stall_ok = 1'b0;
                end
                chk("len5_ignored", 64'(stall_ok), 64'd1);

`ifdef I2C_CLK_STRETCH_EN
                // slave stretches SCL for 20 cycles during address bit 3
                fbegin(); fbyte(8'hAA, 1'b0, 1'b0, 1'b1); fpush();
                exp_done.push_back(1'b0);
                run_txn(7'h55, 1'b0, 3'd0);
                repeat (67) @(posedge clk);
                #1 scl_hold = 1'b1;
                repeat (20) @(posedge clk);
                #1 scl_hold = 1'b0;
                wait_done(108);
`endif

                repeat (10) @(negedge clk);
                chk("frames_left", 64'(exp_frames.size()), 64'd0);
                chk("rdata_left", 64'(exp_rdata.size()), 64'd0);
                chk("done_left", 64'(exp_done.size()), 64'd0);
            end

            begin : wdrv
                forever begin
                    @(negedge clk);
                    if (wvalid && wready) begin
                        @(posedge clk); #1;
                        if (wq.size() > 0) void'(wq.pop_front());
                    end
                    wvalid = (wq.size() > 0);
                    wdata  = (wq.size() > 0) ? wq[0] : 8'h00;
                end
            end

            begin : mon
                forever begin
                    @(negedge clk);
                    if (reset) begin
                        in_txn = 1'b0;
                        slave_drive = 1'b0;
                    end else begin
                        if (p_scl && scl_i && p_sda && !sda_i) begin
                            in_txn = 1'b1;
                            nbits = 0;
                            cur = '0;
                            slave_drive = script[0];
                        end else if (p_scl && scl_i && !p_sda && sda_i && in_txn) begin
                            // the SCL rise inside STOP is not a data bit
                            nbits = nbits - 1;
                            in_txn = 1'b0;
                            slave_drive = 1'b0;
                            if (exp_frames.size() == 0) begin
                                checks++; errors++;
                                $display("FAIL frame: unexpected bus frame of %0d bits", nbits);
                            end else begin
                                fpop = exp_frames.pop_front();
                                mask = (64'd1 << fpop.n) - 64'd1;
                                chk("frame_len", 64'(nbits), 64'(fpop.n));
                                chk("frame_bits", cur & mask, fpop.bits & mask);
                            end
                        end else if (!p_scl && scl_i && in_txn) begin
                            cur[nbits] = sda_i;
                            nbits++;
                        end else if (p_scl && !scl_i && in_txn) begin
                            slave_drive = script[nbits];
                        end
                        if (rvalid) begin
                            if (exp_rdata.size() == 0) begin
                                checks++; errors++;
                                $display("FAIL rdata: unexpected rvalid with %0h", rdata);
                            end else begin
                                chk("rdata", 64'(rdata), 64'(exp_rdata.pop_front()));
                            end
                        end
                        if (done) begin
                            if (exp_done.size() == 0) begin
                                checks++; errors++;
                                $display("FAIL done: unexpected done pulse");
                            end else begin
                                chk("ack_err_at_done", 64'(ack_err), 64'(exp_done.pop_front()));
                            end
                        end
                        if (wready && !p_wready) wr_rises++;
                    end
                    p_scl = scl_i;
                    p_sda = sda_i;
                    p_wready = wready;
                end
            end

            begin : wdog
                repeat (40000) @(posedge clk);
                checks++; errors++;
                $display("FAIL watchdog: got timeout expected end of stimulus");
            end
        join_any
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
